// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave: UART command port. Receives 8N1 bytes on RX, assembles them
// MSB-byte-first into 24-bit commands for the dispatcher, and serialises
// 8-bit response bytes onto TX. RX and TX paths are fully independent.
module uart_cmd_slave #(
  parameter int unsigned BAUD_DIV  = 2604,
  parameter int unsigned TIMEOUT_B = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int unsigned CW = $clog2(BAUD_DIV * TIMEOUT_B) + 1;
  localparam logic [CW-1:0] BitLast  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] ToLast   = CW'(BAUD_DIV * TIMEOUT_B - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // RX synchroniser and edge-detect history
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Receiver state
  rx_state_e      rx_state_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_shift_q;
  logic [1:0]     byte_cnt_q;
  logic [15:0]    shadow_q;
  logic [CW-1:0]  idle_cnt_q;
  logic [23:0]    cmd_q;
  logic           cmd_rdy_q;
  logic           frm_err_q;

  // Transmitter state
  tx_state_e      tx_state_q;
  logic [CW-1:0]  tx_cnt_q;
  logic [2:0]     tx_bit_q;
  logic [7:0]     tx_shift_q;
  logic           tx_q;
  logic           tx_busy_q;
  logic           resp_sent_q;

  // Two-flop synchroniser on the asynchronous RX line, plus a history flop for edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver FSM with command assembly, inter-byte timeout and sticky framing error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      idle_cnt_q <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      // A completion later in this block overrides the clear (set wins)
      if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;

      // Partial command is abandoned if the line stays idle too long between bytes
      if (rx_state_q == RxIdle && byte_cnt_q != 2'd0) begin
        if (idle_cnt_q == ToLast) begin
          byte_cnt_q <= '0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end

      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          // Re-check at mid start bit; a line back high was only a glitch
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            if (!rx_sync_q) begin
              frm_err_q  <= 1'b1;
              byte_cnt_q <= '0;
            end else if (!cmd_rdy_q) begin
              // Bytes arriving while cmd is unconsumed are dropped
              unique case (byte_cnt_q)
                2'd0: begin
                  shadow_q[15:8] <= rx_shift_q;
                  byte_cnt_q     <= 2'd1;
                end
                2'd1: begin
                  shadow_q[7:0] <= rx_shift_q;
                  byte_cnt_q    <= 2'd2;
                end
                default: begin
                  cmd_q      <= {shadow_q, rx_shift_q};
                  cmd_rdy_q  <= 1'b1;
                  byte_cnt_q <= '0;
                end
              endcase
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Transmitter FSM: start, d[0]..d[7], stop, each BAUD_DIV cycles; outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      unique case (tx_state_q)
        TxIdle: begin
          // A strobe coinciding with the completion pulse is ignored
          if (send_resp && !resp_sent_q) begin
            tx_shift_q <= resp;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_state_q <= TxStart;
          end
        end
        TxStart: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TxData;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TxData: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TxStop;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TxStop: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q    <= '0;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b1;
            tx_state_q  <= TxIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: a host-side UART driver/receiver and a command-level
// reference model (byte list -> command rules), with random commands and responses.
module tb_uart_cmd_slave;

  localparam int BD = 16;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [23:0] m_cmd;
  logic        m_rdy;
  int          m_cnt;
  logic [7:0]  m_b0, m_b1;
  logic        m_frm;

  uart_cmd_slave #(.BAUD_DIV(BD), .TIMEOUT_B(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cmd = '0; m_rdy = 1'b0; m_cnt = 0; m_b0 = '0; m_b1 = '0; m_frm = 1'b0;
  endtask

  // Apply one received byte to the command rules
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_frm = 1'b1;
      m_cnt = 0;
    end else if (!m_rdy) begin
      if (m_cnt == 0) m_b0 = b;
      else if (m_cnt == 1) m_b1 = b;
      else begin
        m_cmd = {m_b0, m_b1, b};
        m_rdy = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 3;
    end
  endtask

  task automatic model_idle(input int bits);
    if (bits > TO) m_cnt = 0;
  endtask

  // Host-side 8N1 byte followed by one idle bit-time
  task automatic host_byte(input logic [7:0] b, input bit good);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = good;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
    model_byte(b, good);
  endtask

  task automatic host_cmd(input logic [23:0] c);
    host_byte(c[23:16], 1'b1);
    host_byte(c[15:8], 1'b1);
    host_byte(c[7:0], 1'b1);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  // Send one response and watch TX like a host receiver; optional extra strobes
  // mid-frame and on the completion-pulse cycle, both of which must be ignored
  task automatic tx_check(input string name, input logic [7:0] r, input bit poke);
    logic [7:0] got;
    logic       start_bit, stop_bit;
    int         nsent, sent_k;
    bit         busy_bad, idle_bad;
    got = '0; start_bit = 1'b1; stop_bit = 1'b0;
    nsent = 0; sent_k = -1; busy_bad = 0; idle_bad = 0;
    @(negedge clk);
    resp = r;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int k = 0; k <= 175; k++) begin
      if (k == 8) start_bit = TX;
      if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) got[k/16 - 1] = TX;
      if (k == 152) stop_bit = TX;
      if (resp_sent === 1'b1) begin nsent++; sent_k = k; end
      if (k < 160 && tx_busy !== 1'b1) busy_bad = 1;
      if (k > 160 && (tx_busy !== 1'b0 || TX !== 1'b1)) idle_bad = 1;
      if (poke && (k == 50 || k == 160)) begin
        resp = ~r;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
      @(negedge clk);
    end
    vecs++;
    if (got !== r) begin
      errs++; $display("FAIL %s data: got %h expected %h", name, got, r);
    end
    vecs++;
    if (start_bit !== 1'b0 || stop_bit !== 1'b1) begin
      errs++; $display("FAIL %s framing: start=%b stop=%b expected 0/1", name, start_bit, stop_bit);
    end
    vecs++;
    if (nsent != 1 || sent_k != 160) begin
      errs++; $display("FAIL %s resp_sent: pulses=%0d at %0d expected 1 at 160", name, nsent, sent_k);
    end
    vecs++;
    if (busy_bad || idle_bad) begin
      errs++; $display("FAIL %s tx_busy/idle: busy_bad=%0d idle_bad=%0d expected 0/0", name,
                       busy_bad, idle_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    vecs++;
    if (TX !== 1'b1 || tx_busy !== 1'b0 || resp_sent !== 1'b0) begin
      errs++; $display("FAIL reset_tx: TX=%b busy=%b sent=%b expected 1/0/0", TX, tx_busy, resp_sent);
    end
    vecs++;
    if (cmd !== 24'h0 || cmd_rdy !== 1'b0 || frm_err !== 1'b0) begin
      errs++; $display("FAIL reset_rx: cmd=%h rdy=%b frm=%b expected 0/0/0", cmd, cmd_rdy, frm_err);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    host_cmd(24'h02_00_1C);
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL basic_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
    host_cmd(24'h03_00_2E);
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL held_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
    clear_rdy();
    vecs++;
    if (cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL clr_rdy: rdy=%b expected %b", cmd_rdy, m_rdy);
    end
    host_cmd(24'h03_00_2E);
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL second_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
    clear_rdy();
  endtask

  task automatic test_random_cmds();
    logic [23:0] c;
    for (int n = 0; n < 4; n++) begin
      c = 24'($urandom);
      host_cmd(c);
      vecs++;
      if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
        errs++; $display("FAIL rand_cmd%0d: cmd=%h rdy=%b expected %h/%b", n, cmd, cmd_rdy, m_cmd, m_rdy);
      end
      clear_rdy();
      vecs++;
      if (cmd_rdy !== m_rdy) begin
        errs++; $display("FAIL rand_clr%0d: rdy=%b expected %b", n, cmd_rdy, m_rdy);
      end
    end
  endtask

  task automatic test_timeout();
    host_byte(8'($urandom), 1'b1);
    host_byte(8'($urandom), 1'b1);
    repeat (40 * BD) @(negedge clk);
    model_idle(40);
    vecs++;
    if (cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL timeout_idle: rdy=%b expected %b", cmd_rdy, m_rdy);
    end
    host_cmd(24'h05_00_02);
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL timeout_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
    clear_rdy();
  endtask

  task automatic test_glitch();
    logic [7:0] b0, b1, b2;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    host_byte(b0, 1'b1);
    RX = 1'b0;
    repeat (8) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    vecs++;
    if (cmd_rdy !== 1'b0) begin
      errs++; $display("FAIL glitch_rdy: rdy=%b expected 0", cmd_rdy);
    end
    host_byte(b1, 1'b1);
    host_byte(b2, 1'b1);
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL glitch_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
    clear_rdy();
  endtask

  task automatic test_frame_err();
    vecs++;
    if (frm_err !== m_frm) begin
      errs++; $display("FAIL frm_before: frm=%b expected %b", frm_err, m_frm);
    end
    host_byte(8'($urandom), 1'b1);
    host_byte(8'($urandom), 1'b0);
    vecs++;
    if (frm_err !== m_frm) begin
      errs++; $display("FAIL frm_set: frm=%b expected %b", frm_err, m_frm);
    end
    host_cmd(24'($urandom));
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy || frm_err !== m_frm) begin
      errs++; $display("FAIL frm_cmd: cmd=%h rdy=%b frm=%b expected %h/%b/%b", cmd, cmd_rdy,
                       frm_err, m_cmd, m_rdy, m_frm);
    end
    clear_rdy();
  endtask

  task automatic test_tx();
    tx_check("tx_a5", 8'hA5, 1'b1);
    for (int n = 0; n < 2; n++) tx_check("tx_rand", 8'($urandom), 1'b0);
  endtask

  // Receive a command while a response is going out
  task automatic test_full_duplex();
    logic [23:0] c;
    c = 24'($urandom);
    fork
      host_cmd(c);
      tx_check("duplex_tx", 8'($urandom), 1'b0);
    join
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errs++; $display("FAIL duplex_cmd: cmd=%h rdy=%b expected %h/%b", cmd, cmd_rdy, m_cmd, m_rdy);
    end
  endtask

  task automatic test_tx_reset();
    int nsent;
    nsent = 0;
    @(negedge clk);
    resp = 8'($urandom);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    vecs++;
    if (TX !== 1'b1 || tx_busy !== 1'b0) begin
      errs++; $display("FAIL txrst_line: TX=%b busy=%b expected 1/0", TX, tx_busy);
    end
    vecs++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy || frm_err !== m_frm) begin
      errs++; $display("FAIL txrst_rx: cmd=%h rdy=%b frm=%b expected %h/%b/%b", cmd, cmd_rdy,
                       frm_err, m_cmd, m_rdy, m_frm);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12 * BD; k++) begin
      if (resp_sent === 1'b1) nsent++;
      @(negedge clk);
    end
    vecs++;
    if (nsent != 0) begin
      errs++; $display("FAIL txrst_sent: pulses=%0d expected 0", nsent);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_cmds();
    test_timeout();
    test_glitch();
    test_frame_err();
    test_tx();
    test_full_duplex();
    test_tx_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
